// File: rtl/stump_run_ctrl.sv
// ---------------------------------------------------------------------------
// StumpRunCtrl - run/debug controller for the Stump processor
//
// Runs, halts and single-steps the Stump CPU by gating its clock enable. Also
// holds one instruction breakpoint on the fetch address, counts executed
// instructions and drives the CPU reset.
//
// Ports
//   clk, rst     system clock and synchronous active-high master reset
//   cmd_valid    host command valid
//   cmd_ready    controller can accept a command (HALTED or RUN, rst low)
//   cmd_op       0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SET_BP, 5 CLR_BP,
//                6 RESET_CPU, 7 CLR_CNT
//   cmd_data     breakpoint address for SET_BP
//   fetch        Stump is in its fetch state
//   address      Stump memory address (the PC while fetching)
//   cpu_en       Stump clock enable
//   cpu_rst      Stump reset
//   halted       controller is in HALTED
//   step_done    one-cycle pulse when a single step completes
//   bp_hit       sticky flag: the CPU stopped on the breakpoint
//   instr_count  enabled fetch cycles since the last clear
// ---------------------------------------------------------------------------
module stump_run_ctrl #(
  parameter int unsigned COUNT_W      = 32,
  parameter int unsigned RST_CYCLES   = 2,
  parameter bit          RUN_ON_RESET = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [15:0]        cmd_data,
  input  logic               fetch,
  input  logic [15:0]        address,
  output logic               cpu_en,
  output logic               cpu_rst,
  output logic               halted,
  output logic               step_done,
  output logic               bp_hit,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [2:0] OP_RUN       = 3'd1;
  localparam logic [2:0] OP_HALT      = 3'd2;
  localparam logic [2:0] OP_STEP      = 3'd3;
  localparam logic [2:0] OP_SET_BP    = 3'd4;
  localparam logic [2:0] OP_CLR_BP    = 3'd5;
  localparam logic [2:0] OP_RESET_CPU = 3'd6;
  localparam logic [2:0] OP_CLR_CNT   = 3'd7;

  typedef enum logic [1:0] {
    ST_HALTED,
    ST_RUN,
    ST_STEP,
    ST_CPURST
  } state_e;

  localparam state_e RESET_STATE = RUN_ON_RESET ? ST_RUN : ST_HALTED;

  state_e             state_q, state_d;
  logic               bp_en_q, bp_en_d;
  logic [15:0]        bp_addr_q, bp_addr_d;
  logic               bp_skip_q, bp_skip_d;
  logic               seen_fetch_q, seen_fetch_d;
  logic               bp_hit_q, bp_hit_d;
  logic               step_done_q, step_done_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [RCW-1:0]     rst_cnt_q, rst_cnt_d;

  logic accept;
  logic brk;
  logic fetch_en;

  // Clock-enable gating. The breakpoint fires on the fetch cycle itself so the
  // trapped instruction never executes; bp_skip lets a resumed RUN pass over
  // the instruction it stopped on. In STEP the second fetch seen is the next
  // instruction, which must stay frozen.
  always_comb begin
    brk    = fetch && bp_en_q && (address == bp_addr_q) && !bp_skip_q;
    cpu_en = 1'b0;
    case (state_q)
      ST_RUN:  cpu_en = !brk;
      ST_STEP: cpu_en = !(fetch && seen_fetch_q);
      default: cpu_en = 1'b0;
    endcase
    fetch_en  = fetch && cpu_en;
    cmd_ready = !rst && ((state_q == ST_HALTED) || (state_q == ST_RUN));
    accept    = cmd_valid && cmd_ready;
  end

  // Next-state logic. State-specific behaviour is evaluated first; commands
  // valid in both HALTED and RUN come last so RESET_CPU and CLR_CNT override
  // a breakpoint or an enabled fetch in the same cycle.
  always_comb begin
    state_d      = state_q;
    bp_en_d      = bp_en_q;
    bp_addr_d    = bp_addr_q;
    bp_skip_d    = bp_skip_q;
    seen_fetch_d = seen_fetch_q;
    bp_hit_d     = bp_hit_q;
    step_done_d  = 1'b0;
    count_d      = count_q;
    rst_cnt_d    = rst_cnt_q;

    if (fetch_en) begin
      count_d   = count_q + 1'b1;
      bp_skip_d = 1'b0;
    end

    case (state_q)
      ST_HALTED: begin
        if (accept && (cmd_op == OP_RUN)) begin
          state_d   = ST_RUN;
          bp_skip_d = 1'b1;
          bp_hit_d  = 1'b0;
        end else if (accept && (cmd_op == OP_STEP)) begin
          state_d      = ST_STEP;
          seen_fetch_d = 1'b0;
          bp_skip_d    = 1'b1;
          bp_hit_d     = 1'b0;
        end
      end
      ST_RUN: begin
        if (brk) begin
          state_d  = ST_HALTED;
          bp_hit_d = 1'b1;
        end
        if (accept && (cmd_op == OP_HALT)) begin
          state_d = ST_HALTED;
        end
      end
      ST_STEP: begin
        if (fetch_en) begin
          seen_fetch_d = 1'b1;
        end
        if (fetch && seen_fetch_q) begin
          state_d     = ST_HALTED;
          step_done_d = 1'b1;
        end
      end
      ST_CPURST: begin
        if (rst_cnt_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          rst_cnt_d = rst_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_HALTED;
    endcase

    if (accept) begin
      case (cmd_op)
        OP_SET_BP: begin
          bp_addr_d = cmd_data;
          bp_en_d   = 1'b1;
        end
        OP_CLR_BP: bp_en_d = 1'b0;
        OP_RESET_CPU: begin
          state_d   = ST_CPURST;
          rst_cnt_d = RCW'(RST_CYCLES - 1);
          count_d   = '0;
          bp_hit_d  = 1'b0;
          bp_skip_d = 1'b0;
        end
        OP_CLR_CNT: count_d = '0;
        default: ;
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RESET_STATE;
      bp_en_q      <= 1'b0;
      bp_addr_q    <= '0;
      bp_skip_q    <= 1'b0;
      seen_fetch_q <= 1'b0;
      bp_hit_q     <= 1'b0;
      step_done_q  <= 1'b0;
      count_q      <= '0;
      rst_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      bp_en_q      <= bp_en_d;
      bp_addr_q    <= bp_addr_d;
      bp_skip_q    <= bp_skip_d;
      seen_fetch_q <= seen_fetch_d;
      bp_hit_q     <= bp_hit_d;
      step_done_q  <= step_done_d;
      count_q      <= count_d;
      rst_cnt_q    <= rst_cnt_d;
    end
  end

  assign cpu_rst     = rst || (state_q == ST_CPURST);
  assign halted      = (state_q == ST_HALTED);
  assign step_done   = step_done_q;
  assign bp_hit      = bp_hit_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_stump_run_ctrl.sv
// ---------------------------------------------------------------------------
// TbStumpRunCtrl - self-checking bench for stump_run_ctrl
//
// A small instruction-level Stump stand-in (PC plus phase within a 2- or
// 3-cycle instruction) is driven by cpu_en/cpu_rst. Expected instruction
// counts are derived from how many instructions the stand-in has started.
// ---------------------------------------------------------------------------
module tb_stump_run_ctrl;

  localparam int CW = 4;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_RUN       = 3'd1;
  localparam logic [2:0] OP_HALT      = 3'd2;
  localparam logic [2:0] OP_STEP      = 3'd3;
  localparam logic [2:0] OP_SET_BP    = 3'd4;
  localparam logic [2:0] OP_CLR_BP    = 3'd5;
  localparam logic [2:0] OP_RESET_CPU = 3'd6;
  localparam logic [2:0] OP_CLR_CNT   = 3'd7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = OP_NOP;
  logic [15:0]   cmd_data = 16'h0;
  logic          fetch;
  logic [15:0]   address;
  logic          cpu_en;
  logic          cpu_rst;
  logic          halted;
  logic          step_done;
  logic          bp_hit;
  logic [CW-1:0] instr_count;

  int checkCount = 0;
  int failCount  = 0;
  int expCount   = 0;
  bit bpHitExp   = 1'b0;

  int enCycles   = 0;
  int rstCycles  = 0;
  int stepPulses = 0;

  // Stump stand-in: cycle lengths per instruction, indexed by PC[3:0]
  int          lens [16] = '{2, 2, 2, 2, 2, 3, 2, 2, 3, 2, 2, 2, 3, 2, 2, 2};
  logic [15:0] pc = 16'h0;
  int          ph = 0;

  stump_run_ctrl #(.COUNT_W(CW), .RST_CYCLES(2), .RUN_ON_RESET(1'b0)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .fetch(fetch), .address(address),
    .cpu_en(cpu_en), .cpu_rst(cpu_rst), .halted(halted),
    .step_done(step_done), .bp_hit(bp_hit), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic int ilen(input logic [15:0] p);
    return lens[p[3:0]];
  endfunction

  // Number of instructions whose fetch has already happened at (p, phase).
  function automatic int started(input logic [15:0] p, input int phase);
    return int'(p) + ((phase > 0) ? 1 : 0);
  endfunction

  // CPU stand-in advances only while enabled and restarts at PC 0 on reset.
  assign fetch   = (ph == 0);
  assign address = (ph == 0) ? pc : (pc ^ 16'h8000);

  always @(posedge clk) begin
    if (cpu_rst) begin
      pc <= 16'h0;
      ph <= 0;
    end else if (cpu_en) begin
      if (ph == ilen(pc) - 1) begin
        pc <= pc + 16'h1;
        ph <= 0;
      end else begin
        ph <= ph + 1;
      end
    end
  end

  // Activity monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (cpu_en) enCycles <= enCycles + 1;
    if (cpu_rst) rstCycles <= rstCycles + 1;
    if (step_done) stepPulses <= stepPulses + 1;
  end

  // Drive one command for one cycle, starting just after a rising edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] data);
    checkCount++;
    if (cmd_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL cmd_ready_before_op%0d: got %b expected 1", op, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = 16'h0;
  endtask

  task automatic wait_halted(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (halted === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // RUN, then HALT in the last cycle of instruction target-1 so the CPU
  // stops at the fetch of instruction target.
  task automatic run_halt(input int target);
    bit found;
    found = 1'b0;
    applyStimulus(OP_RUN, 16'h0);
    for (int i = 0; i < 400; i++) begin
      if ((int'(pc) == target - 1) && (ph == ilen(pc) - 1)) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkCount++;
    if (!found) begin
      failCount++;
      $display("[TB] FAIL run_halt_timeout: pc %0d never reached target %0d", pc, target);
    end
    applyStimulus(OP_HALT, 16'h0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if (cpu_rst !== 1'b1) begin failCount++; $display("[TB] FAIL reset_cpu_rst: got %b expected 1", cpu_rst); end
    checkCount++;
    if (cmd_ready !== 1'b0) begin failCount++; $display("[TB] FAIL reset_cmd_ready_in_rst: got %b expected 0", cmd_ready); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkCount++;
    if (halted !== 1'b1) begin failCount++; $display("[TB] FAIL reset_halted: got %b expected 1", halted); end
    checkCount++;
    if (cpu_en !== 1'b0) begin failCount++; $display("[TB] FAIL reset_cpu_en: got %b expected 0", cpu_en); end
    checkCount++;
    if (instr_count !== CW'(0)) begin failCount++; $display("[TB] FAIL reset_count: got %0d expected 0", instr_count); end
    checkCount++;
    if (cmd_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    checkCount++;
    if ({bp_hit, step_done, cpu_rst} !== 3'b000) begin failCount++; $display("[TB] FAIL reset_flags: got %b expected 000", {bp_hit, step_done, cpu_rst}); end
    expCount = 0;
  endtask

  task automatic test_run_halt;
    int en0;
    run_halt(3);
    expCount = 3;
    checkCount++;
    if (instr_count !== CW'(expCount)) begin failCount++; $display("[TB] FAIL run_halt_count: got %0d expected %0d", instr_count, expCount); end
    checkCount++;
    if (halted !== 1'b1) begin failCount++; $display("[TB] FAIL run_halt_halted: got %b expected 1", halted); end
    en0 = enCycles;
    repeat (4) @(posedge clk);
    #1;
    checkCount++;
    if ((enCycles != en0) || (pc !== 16'd3) || (ph != 0)) begin
      failCount++;
      $display("[TB] FAIL run_halt_frozen: en cycles %0d pc %0d ph %0d expected 0, 3, 0", enCycles - en0, pc, ph);
    end
  endtask

  task automatic test_reset_cpu;
    int r0;
    bit ok;
    applyStimulus(OP_SET_BP, 16'h0004);
    r0 = rstCycles;
    applyStimulus(OP_RESET_CPU, 16'h0);
    wait_halted(20, ok);
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if (!ok || (rstCycles - r0 != 2)) begin failCount++; $display("[TB] FAIL reset_cpu_pulse: got %0d cycles (halted %b) expected 2", rstCycles - r0, ok); end
    expCount = 0;
    checkCount++;
    if (instr_count !== CW'(0)) begin failCount++; $display("[TB] FAIL reset_cpu_count: got %0d expected 0", instr_count); end
    checkCount++;
    if ((halted !== 1'b1) || (pc !== 16'h0)) begin failCount++; $display("[TB] FAIL reset_cpu_state: halted %b pc %0d expected 1, 0", halted, pc); end
  endtask

  task automatic test_breakpoint;
    bit ok;
    applyStimulus(OP_RUN, 16'h0);
    wait_halted(100, ok);
    expCount = 4;
    checkCount++;
    if (!ok || (address !== 16'h0004) || (fetch !== 1'b1)) begin failCount++; $display("[TB] FAIL bp_stop_addr: got %h fetch %b expected 0004 fetch 1", address, fetch); end
    checkCount++;
    if (bp_hit !== 1'b1) begin failCount++; $display("[TB] FAIL bp_hit_set: got %b expected 1", bp_hit); end
    checkCount++;
    if (instr_count !== CW'(expCount)) begin failCount++; $display("[TB] FAIL bp_count: got %0d expected %0d", instr_count, expCount); end
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if ((pc !== 16'h0004) || (ph != 0) || (cpu_en !== 1'b0)) begin failCount++; $display("[TB] FAIL bp_frozen: pc %0d ph %0d en %b expected 4, 0, 0", pc, ph, cpu_en); end
    applyStimulus(OP_RUN, 16'h0);
    checkCount++;
    if (bp_hit !== 1'b0) begin failCount++; $display("[TB] FAIL bp_hit_clear: got %b expected 0", bp_hit); end
    applyStimulus(OP_SET_BP, 16'h0005);
    wait_halted(100, ok);
    expCount = 5;
    checkCount++;
    if (!ok || (pc !== 16'h0005) || (ph != 0) || (bp_hit !== 1'b1)) begin failCount++; $display("[TB] FAIL bp_resume: pc %0d ph %0d bp_hit %b expected 5, 0, 1", pc, ph, bp_hit); end
    checkCount++;
    if (instr_count !== CW'(expCount)) begin failCount++; $display("[TB] FAIL bp_resume_count: got %0d expected %0d", instr_count, expCount); end
  endtask

  task automatic test_step;
    int en0, sp0, expEn;
    bit ok;
    bit readyLow;
    expEn = ilen(pc);
    en0 = enCycles;
    sp0 = stepPulses;
    readyLow = 1'b1;
    applyStimulus(OP_STEP, 16'h0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (halted === 1'b1) begin ok = 1'b1; break; end
      if (cmd_ready !== 1'b0) readyLow = 1'b0;
      @(posedge clk);
      #1;
    end
    expCount = expCount + 1;
    checkCount++;
    if (!readyLow) begin failCount++; $display("[TB] FAIL step_cmd_ready: got 1 during step expected 0"); end
    checkCount++;
    if (!ok || (step_done !== 1'b1)) begin failCount++; $display("[TB] FAIL step_done_pulse: got %b (halted %b) expected 1", step_done, ok); end
    checkCount++;
    if (enCycles - en0 != expEn) begin failCount++; $display("[TB] FAIL step_en_cycles: got %0d expected %0d", enCycles - en0, expEn); end
    @(posedge clk);
    #1;
    checkCount++;
    if ((step_done !== 1'b0) || (stepPulses - sp0 != 1)) begin failCount++; $display("[TB] FAIL step_done_once: pulses %0d now %b expected 1, 0", stepPulses - sp0, step_done); end
    checkCount++;
    if ((instr_count !== CW'(expCount)) || (pc !== 16'h0006) || (ph != 0)) begin failCount++; $display("[TB] FAIL step_result: count %0d pc %0d expected %0d, 6", instr_count, pc, expCount); end
  endtask

  task automatic test_wrap;
    applyStimulus(OP_CLR_BP, 16'h0);
    applyStimulus(OP_CLR_CNT, 16'h0);
    run_halt(int'(pc) + 17);
    expCount = 17;
    checkCount++;
    if (instr_count !== CW'(expCount)) begin failCount++; $display("[TB] FAIL wrap_count: got %0d expected %0d", instr_count, expCount % 16); end
  endtask

  task automatic test_clr_cnt_race;
    int s0;
    applyStimulus(OP_RUN, 16'h0);
    for (int i = 0; i < 10; i++) begin
      if (ph == 0) break;
      @(posedge clk);
      #1;
    end
    applyStimulus(OP_CLR_CNT, 16'h0);
    checkCount++;
    if (instr_count !== CW'(0)) begin failCount++; $display("[TB] FAIL clr_cnt_wins: got %0d expected 0", instr_count); end
    s0 = started(pc, ph);
    applyStimulus(OP_HALT, 16'h0);
    expCount = started(pc, ph) - s0;
    checkCount++;
    if (instr_count !== CW'(expCount)) begin failCount++; $display("[TB] FAIL clr_cnt_after: got %0d expected %0d", instr_count, expCount % 16); end
  endtask

  task automatic test_brk_and_halt;
    logic [15:0] bp;
    int s0;
    bit found;
    s0 = started(pc, ph);
    bp = 16'(s0 + 2);
    applyStimulus(OP_SET_BP, bp);
    applyStimulus(OP_RUN, 16'h0);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if ((pc == bp) && (ph == 0) && (halted === 1'b0)) begin found = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    applyStimulus(OP_HALT, 16'h0);
    expCount = expCount + int'(bp) - s0;
    bpHitExp = 1'b1;
    checkCount++;
    if (!found || (halted !== 1'b1) || (bp_hit !== 1'b1) || (pc !== bp)) begin
      failCount++;
      $display("[TB] FAIL brk_and_halt: halted %b bp_hit %b pc %0d expected 1, 1, %0d", halted, bp_hit, pc, bp);
    end
    checkCount++;
    if (instr_count !== CW'(expCount)) begin failCount++; $display("[TB] FAIL brk_and_halt_count: got %0d expected %0d", instr_count, expCount % 16); end
  endtask

  task automatic test_random;
    int op, s0, waitN;
    logic [15:0] bp;
    bit ok;
    for (int it = 0; it < 24; it++) begin
      op = $urandom_range(0, 3);
      s0 = started(pc, ph);
      ok = 1'b1;
      case (op)
        0: begin
          applyStimulus(OP_STEP, 16'h0);
          wait_halted(30, ok);
          expCount = expCount + 1;
          bpHitExp = 1'b0;
          checkCount++;
          if ((int'(pc) != s0 + 1) || (ph != 0)) begin failCount++; $display("[TB] FAIL rand_step_pc: got %0d ph %0d expected %0d, 0", pc, ph, s0 + 1); end
        end
        1: begin
          applyStimulus(OP_CLR_BP, 16'h0);
          applyStimulus(OP_RUN, 16'h0);
          waitN = $urandom_range(0, 8);
          repeat (waitN) @(posedge clk);
          #1;
          applyStimulus(OP_HALT, 16'h0);
          expCount = expCount + started(pc, ph) - s0;
          bpHitExp = 1'b0;
        end
        2: begin
          bp = 16'(s0 + $urandom_range(1, 4));
          applyStimulus(OP_SET_BP, bp);
          applyStimulus(OP_RUN, 16'h0);
          wait_halted(80, ok);
          expCount = expCount + int'(bp) - s0;
          bpHitExp = 1'b1;
          checkCount++;
          if ((pc !== bp) || (ph != 0)) begin failCount++; $display("[TB] FAIL rand_bp_pc: got %0d ph %0d expected %0d, 0", pc, ph, bp); end
        end
        default: begin
          applyStimulus(OP_CLR_CNT, 16'h0);
          expCount = 0;
        end
      endcase
      checkCount++;
      if (!ok || (halted !== 1'b1)) begin failCount++; $display("[TB] FAIL rand_halted it%0d op%0d: got %b expected 1", it, op, halted); end
      checkCount++;
      if (instr_count !== CW'(expCount)) begin failCount++; $display("[TB] FAIL rand_count it%0d op%0d: got %0d expected %0d", it, op, instr_count, expCount % 16); end
      checkCount++;
      if (bp_hit !== bpHitExp) begin failCount++; $display("[TB] FAIL rand_bp_hit it%0d op%0d: got %b expected %b", it, op, bp_hit, bpHitExp); end
    end
  endtask

  task automatic test_rst_mid_step;
    int sp0;
    sp0 = stepPulses;
    applyStimulus(OP_STEP, 16'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkCount++;
    if ((cpu_rst !== 1'b1) || (cmd_ready !== 1'b0) || (halted !== 1'b1)) begin
      failCount++;
      $display("[TB] FAIL rst_mid_step_now: cpu_rst %b cmd_ready %b halted %b expected 1, 0, 1", cpu_rst, cmd_ready, halted);
    end
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkCount++;
    if (stepPulses != sp0) begin failCount++; $display("[TB] FAIL rst_mid_step_done: got %0d pulses expected 0", stepPulses - sp0); end
    checkCount++;
    if ((halted !== 1'b1) || (instr_count !== CW'(0)) || (bp_hit !== 1'b0) || (pc !== 16'h0)) begin
      failCount++;
      $display("[TB] FAIL rst_mid_step_state: halted %b count %0d bp_hit %b pc %0d expected 1, 0, 0, 0", halted, instr_count, bp_hit, pc);
    end
  endtask

  // Test sequence; each task leaves the controller halted for the next one.
  initial begin
    test_reset();
    test_run_halt();
    test_reset_cpu();
    test_breakpoint();
    test_step();
    test_wrap();
    test_clr_cnt_race();
    test_brk_and_halt();
    test_random();
    test_rst_mid_step();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
